// File: rtl/axis_uart_fifo_transceiver.sv
// AXI-Stream UART: TX/RX FIFOs, 16x-oversampled receiver, run-time baud divisor, sticky RX errors.
// Define UART_LOOPBACK_EN to add loopback_en (TX stream fed to RX internally, uart_tx held high).

module axis_uart_fifo_transceiver_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    // Head is read combinationally so the stream side sees first-word-fall-through.
    assign rdata = mem[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
endmodule

module axis_uart_fifo_transceiver #(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY        = 0,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int RX_FIFO_DEPTH = 16,
    parameter int DIV_WIDTH     = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [DIV_WIDTH-1:0]             baud_div,
    input  logic [DATA_BITS-1:0]             s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    output logic [DATA_BITS-1:0]             m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    input  logic                             uart_rx,
`ifdef UART_LOOPBACK_EN
    input  logic                             loopback_en,
`endif
    output logic                             uart_tx,
    output logic                             tx_busy,
    output logic [$clog2(TX_FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level,
    input  logic                             err_clear,
    output logic                             rx_err_frame,
    output logic                             rx_err_parity,
    output logic                             rx_err_overrun
);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]           LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]           LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    logic [DIV_WIDTH-1:0] div_eff;
    assign div_eff = (baud_div == '0) ? DIV_ONE : baud_div;

    // FIFOs
    logic                 tx_push, tx_pop, tx_empty, tx_full;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_push, rx_pop, rx_empty, rx_full;
    logic [DATA_BITS-1:0] rx_head;

    axis_uart_fifo_transceiver_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk(aclk), .rst_n(aresetn), .push(tx_push), .wdata(s_axis_tdata), .pop(tx_pop),
        .rdata(tx_head), .empty(tx_empty), .full(tx_full), .level(tx_level)
    );

    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

    axis_uart_fifo_transceiver_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk(aclk), .rst_n(aresetn), .push(rx_push), .wdata(rx_shift_q), .pop(rx_pop),
        .rdata(rx_head), .empty(rx_empty), .full(rx_full), .level(rx_level)
    );

    // tready stays low while reset is asserted, then follows FIFO space.
    logic rdy_q, rdy_d;
    assign rdy_d         = 1'b1;
    assign s_axis_tready = rdy_q & ~tx_full;
    assign tx_push       = s_axis_tvalid & s_axis_tready;
    assign m_axis_tvalid = ~rx_empty;
    assign m_axis_tdata  = rx_empty ? '0 : rx_head;
    assign rx_pop        = m_axis_tvalid & m_axis_tready;

    // TX datapath
    tx_state_t            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic [DIV_WIDTH-1:0] tx_div_lat_q, tx_div_lat_d, tx_div_cnt_q, tx_div_cnt_d;
    logic [3:0]           tx_sub_q, tx_sub_d, tx_bit_q, tx_bit_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_tick, tx_bit_end, tx_load;

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_shift_d   = tx_shift_q;
        tx_par_d     = tx_par_q;
        tx_div_lat_d = tx_div_lat_q;
        tx_div_cnt_d = tx_div_cnt_q;
        tx_sub_d     = tx_sub_q;
        tx_bit_d     = tx_bit_q;
        tx_load      = 1'b0;
        tx_tick      = (tx_state_q != TX_IDLE) && (tx_div_cnt_q == '0);
        tx_bit_end   = tx_tick && (tx_sub_q == 4'd15);
        if (tx_state_q != TX_IDLE) begin
            if (tx_tick) begin
                tx_div_cnt_d = tx_div_lat_q - DIV_ONE;
                tx_sub_d     = tx_sub_q + 4'd1;
            end else begin
                tx_div_cnt_d = tx_div_cnt_q - DIV_ONE;
            end
        end
        case (tx_state_q)
            TX_IDLE:   tx_load = ~tx_empty;
            TX_START:  if (tx_bit_end) begin
                           tx_state_d = TX_DATA;
                           tx_bit_d   = '0;
                       end
            TX_DATA:   if (tx_bit_end) begin
                           tx_shift_d = tx_shift_q >> 1;
                           if (tx_bit_q == LAST_DATA) begin
                               tx_bit_d   = '0;
                               tx_state_d = (PARITY == 0) ? TX_STOP : TX_PARITY;
                           end else begin
                               tx_bit_d = tx_bit_q + 4'd1;
                           end
                       end
            TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
            TX_STOP:   if (tx_bit_end) begin
                           if (tx_bit_q == LAST_STOP) begin
                               // Chain straight into the next frame so there is no idle gap.
                               if (!tx_empty) tx_load = 1'b1;
                               else           tx_state_d = TX_IDLE;
                           end else begin
                               tx_bit_d = tx_bit_q + 4'd1;
                           end
                       end
            default:   tx_state_d = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_state_d   = TX_START;
            tx_shift_d   = tx_head;
            tx_par_d     = par_bit(tx_head);
            tx_div_lat_d = div_eff;
            tx_div_cnt_d = div_eff - DIV_ONE;
            tx_sub_d     = '0;
            tx_bit_d     = '0;
        end
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_shift_d[0];
            TX_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    assign tx_pop  = tx_load;
    assign tx_busy = ~tx_empty | (tx_state_q != TX_IDLE);

    // RX input select and synchroniser
    logic rx_in;
`ifdef UART_LOOPBACK_EN
    assign rx_in   = loopback_en ? tx_line_q : uart_rx;
    assign uart_tx = loopback_en ? 1'b1 : tx_line_q;
`else
    assign rx_in   = uart_rx;
    assign uart_tx = tx_line_q;
`endif

    logic rx_s1_q, rx_s2_q, rx_prev_q;

    rx_state_t            rx_state_q, rx_state_d;
    logic                 rx_par_q, rx_par_d;
    logic [DIV_WIDTH-1:0] rx_div_lat_q, rx_div_lat_d, rx_div_cnt_q, rx_div_cnt_d;
    logic [3:0]           rx_sub_q, rx_sub_d, rx_bit_q, rx_bit_d;
    logic                 rx_run, rx_tick, rx_sample;
    logic                 frame_set, parity_set, overrun_set;
    logic                 err_frame_q, err_frame_d, err_parity_q, err_parity_d;
    logic                 err_overrun_q, err_overrun_d;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_shift_d   = rx_shift_q;
        rx_par_d     = rx_par_q;
        rx_div_lat_d = rx_div_lat_q;
        rx_div_cnt_d = rx_div_cnt_q;
        rx_sub_d     = rx_sub_q;
        rx_bit_d     = rx_bit_q;
        rx_push      = 1'b0;
        frame_set    = 1'b0;
        parity_set   = 1'b0;
        overrun_set  = 1'b0;
        rx_run       = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT);
        rx_tick      = rx_run && (rx_div_cnt_q == '0);
        rx_sample    = rx_tick && (rx_sub_q == 4'd15);
        if (rx_run) begin
            if (rx_tick) begin
                rx_div_cnt_d = rx_div_lat_q - DIV_ONE;
                rx_sub_d     = rx_sub_q + 4'd1;
            end else begin
                rx_div_cnt_d = rx_div_cnt_q - DIV_ONE;
            end
        end
        case (rx_state_q)
            RX_IDLE:   if (rx_prev_q && !rx_s2_q) begin
                           rx_state_d   = RX_START;
                           rx_div_lat_d = div_eff;
                           rx_div_cnt_d = div_eff - DIV_ONE;
                           rx_sub_d     = '0;
                       end
            // Mid-start check; later samples land every 16 ticks from here.
            RX_START:  if (rx_tick && rx_sub_q == 4'd7) begin
                           rx_sub_d   = '0;
                           rx_bit_d   = '0;
                           rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                       end
            RX_DATA:   if (rx_sample) begin
                           rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                           if (rx_bit_q == LAST_DATA) begin
                               rx_bit_d   = '0;
                               rx_state_d = (PARITY == 0) ? RX_STOP : RX_PARITY;
                           end else begin
                               rx_bit_d = rx_bit_q + 4'd1;
                           end
                       end
            RX_PARITY: if (rx_sample) begin
                           rx_par_d   = rx_s2_q;
                           rx_state_d = RX_STOP;
                       end
            RX_STOP:   if (rx_sample) begin
                           if (!rx_s2_q) begin
                               frame_set  = 1'b1;
                               rx_state_d = RX_WAIT;
                           end else begin
                               rx_state_d = RX_IDLE;
                               if (PARITY != 0 && rx_par_q != par_bit(rx_shift_q)) parity_set = 1'b1;
                               else if (rx_full && !rx_pop)                        overrun_set = 1'b1;
                               else                                                rx_push = 1'b1;
                           end
                       end
            RX_WAIT:   if (rx_s2_q) rx_state_d = RX_IDLE;
            default:   rx_state_d = RX_IDLE;
        endcase
        err_frame_d   = (err_frame_q   & ~err_clear) | frame_set;
        err_parity_d  = (err_parity_q  & ~err_clear) | parity_set;
        err_overrun_d = (err_overrun_q & ~err_clear) | overrun_set;
    end

    assign rx_err_frame   = err_frame_q;
    assign rx_err_parity  = err_parity_q;
    assign rx_err_overrun = err_overrun_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q         <= 1'b0;
            tx_state_q    <= TX_IDLE;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            tx_div_lat_q  <= DIV_ONE;
            tx_div_cnt_q  <= '0;
            tx_sub_q      <= '0;
            tx_bit_q      <= '0;
            tx_line_q     <= 1'b1;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_shift_q    <= '0;
            rx_par_q      <= 1'b0;
            rx_div_lat_q  <= DIV_ONE;
            rx_div_cnt_q  <= '0;
            rx_sub_q      <= '0;
            rx_bit_q      <= '0;
            err_frame_q   <= 1'b0;
            err_parity_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            rdy_q         <= rdy_d;
            tx_state_q    <= tx_state_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            tx_div_lat_q  <= tx_div_lat_d;
            tx_div_cnt_q  <= tx_div_cnt_d;
            tx_sub_q      <= tx_sub_d;
            tx_bit_q      <= tx_bit_d;
            tx_line_q     <= tx_line_d;
            rx_s1_q       <= rx_in;
            rx_s2_q       <= rx_s1_q;
            rx_prev_q     <= rx_s2_q;
            rx_state_q    <= rx_state_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_q      <= rx_par_d;
            rx_div_lat_q  <= rx_div_lat_d;
            rx_div_cnt_q  <= rx_div_cnt_d;
            rx_sub_q      <= rx_sub_d;
            rx_bit_q      <= rx_bit_d;
            err_frame_q   <= err_frame_d;
            err_parity_q  <= err_parity_d;
            err_overrun_q <= err_overrun_d;
        end
    end
endmodule
